// File: rtl/lcd_i2c_target_if.sv
// Avalon-MM register port of lcd_i2c_target: the CPU (master) drives the strobes, the block (slave) returns readdata.
interface lcd_i2c_target_if;
  logic [1:0] address;
  logic       chipselect;
  logic       write_n;
  logic [7:0] writedata;
  logic [7:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/lcd_i2c_target.sv
// I2C target with a 4x8 register file shared with an Avalon-MM CPU port; define LCD_I2C_TGT_FILTER_EN for a FILTER_LEN-clk input glitch filter.
// Latency: 3 clk pin-to-edge detect (plus FILTER_LEN when filtered), 1-clk readdata; no backpressure (no clock stretching, Avalon never stalls).
module lcd_i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h3C,
  parameter int         FILTER_LEN  = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  lcd_i2c_target_if.slave  av,
  output logic             busy,
  output logic             wr_strobe
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  if (FILTER_LEN < 1) begin : g_bad_filter
    $error("FILTER_LEN must be at least 1");
  end

  logic [1:0] scl_sync, sda_sync;
  logic       scl_f, sda_f, scl_d, sda_d;

  // Bus idles high, so the synchroniser resets to 1 to avoid a false START.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
    end
  end

`ifdef LCD_I2C_TGT_FILTER_EN
  localparam int            CW       = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);
  logic [CW-1:0] scl_cnt, sda_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      if (scl_sync[1] == scl_f) scl_cnt <= '0;
      else if (scl_cnt == CNT_LAST) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= '0;
      end else scl_cnt <= scl_cnt + 1'b1;
      if (sda_sync[1] == sda_f) sda_cnt <= '0;
      else if (sda_cnt == CNT_LAST) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= '0;
      end else sda_cnt <= sda_cnt + 1'b1;
    end
  end
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;

  state_t     state, state_nx;
  logic [3:0] bit_cnt, bit_cnt_nx;
  logic [7:0] shift, shift_nx;
  logic [6:0] tx, tx_nx;
  logic [1:0] ptr, ptr_nx, ptr_inc;
  logic       ack_ok, ack_nx, oe_nx, busy_nx, commit, av_we;
  logic [7:0] regs [4];
  logic [7:0] rd_byte, rd_next;

  assign ptr_inc = ptr + 2'd1;
  assign rd_byte = regs[ptr];
  assign rd_next = regs[ptr_inc];
  assign av_we   = av.chipselect & ~av.write_n;

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shift_nx   = shift;
    tx_nx      = tx;
    ptr_nx     = ptr;
    ack_nx     = ack_ok;
    oe_nx      = sda_oe;
    commit     = 1'b0;
    if (stop_det) begin
      state_nx = IDLE;
      oe_nx    = 1'b0;
    end else if (start_det) begin
      state_nx   = ADDR;
      bit_cnt_nx = 4'd0;
      oe_nx      = 1'b0;
    end else if (scl_rise) begin
      case (state)
        ADDR, PTR, WDATA: if (bit_cnt != 4'd8) begin
          shift_nx   = {shift[6:0], sda_f};
          bit_cnt_nx = bit_cnt + 4'd1;
        end
        RDATA:     if (bit_cnt != 4'd8) bit_cnt_nx = bit_cnt + 4'd1;
        RDATA_ACK: ack_nx = ~sda_f;
        default: ;
      endcase
    end else if (scl_fall) begin
      // Every SDA change happens here, while SCL is low.
      case (state)
        ADDR: if (bit_cnt == 4'd8) begin
          if (shift[7:1] == TARGET_ADDR) begin
            state_nx = ADDR_ACK;
            oe_nx    = 1'b1;
          end else state_nx = IDLE;
        end
        ADDR_ACK: begin
          bit_cnt_nx = 4'd0;
          if (shift[0]) begin
            state_nx = RDATA;
            tx_nx    = rd_byte[6:0];
            oe_nx    = ~rd_byte[7];
          end else begin
            state_nx = PTR;
            oe_nx    = 1'b0;
          end
        end
        PTR: if (bit_cnt == 4'd8) begin
          ptr_nx   = shift[1:0];
          state_nx = PTR_ACK;
          oe_nx    = 1'b1;
        end
        WDATA: if (bit_cnt == 4'd8) begin
          commit   = 1'b1;
          ptr_nx   = ptr_inc;
          state_nx = WDATA_ACK;
          oe_nx    = 1'b1;
        end
        PTR_ACK, WDATA_ACK: begin
          state_nx   = WDATA;
          bit_cnt_nx = 4'd0;
          oe_nx      = 1'b0;
        end
        RDATA: if (bit_cnt == 4'd8) begin
          state_nx = RDATA_ACK;
          oe_nx    = 1'b0;
        end else begin
          tx_nx = {tx[5:0], 1'b1};
          oe_nx = ~tx[6];
        end
        RDATA_ACK: if (ack_ok) begin
          ptr_nx     = ptr_inc;
          tx_nx      = rd_next[6:0];
          oe_nx      = ~rd_next[7];
          bit_cnt_nx = 4'd0;
          state_nx   = RDATA;
        end else begin
          state_nx = IDLE;
          oe_nx    = 1'b0;
        end
        default: ;
      endcase
    end
    // busy survives a repeated START; only a return to IDLE clears it.
    busy_nx = (state_nx == ADDR_ACK) ? 1'b1 : (state_nx == IDLE) ? 1'b0 : busy;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      shift     <= 8'd0;
      tx        <= 7'd0;
      ptr       <= 2'd0;
      ack_ok    <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
    end else begin
      state     <= state_nx;
      bit_cnt   <= bit_cnt_nx;
      shift     <= shift_nx;
      tx        <= tx_nx;
      ptr       <= ptr_nx;
      ack_ok    <= ack_nx;
      sda_oe    <= oe_nx;
      busy      <= busy_nx;
      wr_strobe <= commit;
    end
  end

  // CPU write has priority over an I2C commit to the same register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= 8'd0;
      av.readdata <= 8'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (av_we && av.address == 2'(i)) regs[i] <= av.writedata;
        else if (commit && ptr == 2'(i)) regs[i] <= shift;
      end
      av.readdata <= regs[av.address];
    end
  end
endmodule

// File: tb/tb_lcd_i2c_target.sv
// Scoreboard bench for lcd_i2c_target: a bus monitor decodes 9-bit I2C frames off the wired SDA and checks them against queued expectations.
module tb_lcd_i2c_target;
  localparam int Q = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  logic sda_oe, busy, wr_strobe, sda_bus;

  lcd_i2c_target_if av();

  assign sda_bus = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  lcd_i2c_target dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .scl_in    (scl),
    .sda_in    (sda_bus),
    .sda_oe    (sda_oe),
    .av        (av),
    .busy      (busy),
    .wr_strobe (wr_strobe)
  );

  int         checks = 0;
  int         failures = 0;
  int         strobe_cnt = 0;
  logic [8:0] frame_q [$];
  logic [7:0] rd_q [$];
  logic       rd_vld = 1'b0;

  // Bus/Avalon monitor
  logic       scl_p = 1'b1, sda_p = 1'b1, in_frame = 1'b0;
  int         bitn = 0;
  int         frame_no = 0;
  logic [8:0] fsh = 9'd0, fexp;
  logic [7:0] rexp;

  always @(negedge clk) begin
    if (!reset_n) begin
      in_frame = 1'b0;
      bitn     = 0;
    end else begin
      if (scl && scl_p && sda_p && !sda_bus) begin
        in_frame = 1'b1;
        bitn     = 0;
      end else if (scl && scl_p && !sda_p && sda_bus) begin
        in_frame = 1'b0;
      end else if (scl && !scl_p && in_frame) begin
        fsh  = {fsh[7:0], sda_bus};
        bitn = bitn + 1;
        if (bitn == 9) begin
          bitn     = 0;
          frame_no = frame_no + 1;
          checks   = checks + 1;
          if (frame_q.size() == 0) begin
            failures = failures + 1;
            $display("FAIL frame%0d unexpected got=%03h", frame_no, fsh);
          end else begin
            fexp = frame_q.pop_front();
            if (fsh !== fexp) begin
              failures = failures + 1;
              $display("FAIL frame%0d got=%02h ack=%0b exp=%02h ack=%0b",
                       frame_no, fsh[8:1], fsh[0], fexp[8:1], fexp[0]);
            end
          end
        end
      end
      if (wr_strobe) strobe_cnt = strobe_cnt + 1;
    end
    if (rd_vld) begin
      checks = checks + 1;
      rexp   = rd_q.pop_front();
      if (av.readdata !== rexp) begin
        failures = failures + 1;
        $display("FAIL readdata addr=%0d got=%02h exp=%02h", av.address, av.readdata, rexp);
      end
    end
    scl_p = scl;
    sda_p = sda_bus;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%02h exp=%02h", name, act, exp);
    end
  endtask

  task automatic i2c_bit(input logic b);
    sda_m = b;  tick(Q);
    scl   = 1'b1; tick(Q);
    scl   = 1'b0; tick(Q);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; tick(Q);
    scl   = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl   = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; tick(Q);
    scl   = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic i2c_frame(input logic [7:0] drv, input logic ninth,
                           input logic [7:0] exp_b, input logic exp_ack);
    frame_q.push_back({exp_b, exp_ack});
    for (int i = 7; i >= 0; i--) i2c_bit(drv[i]);
    i2c_bit(ninth);
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic exp_ack);
    i2c_frame(b, 1'b1, b, exp_ack);
  endtask

  task automatic rd_byte(input logic [7:0] exp_b, input logic ack);
    i2c_frame(8'hFF, ack, exp_b, ack);
  endtask

  task automatic av_write(input logic [1:0] a, input logic [7:0] d);
    av.address = a; av.writedata = d; av.chipselect = 1'b1; av.write_n = 1'b0;
    tick(1);
    av.chipselect = 1'b0; av.write_n = 1'b1;
  endtask

  task automatic av_read(input logic [1:0] a, input logic [7:0] exp);
    av.address = a;
    tick(1);
    rd_q.push_back(exp);
    rd_vld = 1'b1;
    tick(1);
    rd_vld = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timed out");
  end

  logic [7:0] cd;

  initial begin
    av.address = 2'd0; av.chipselect = 1'b0; av.write_n = 1'b1; av.writedata = 8'd0;
    // Reset held while the bus toggles
    for (int i = 0; i < 6; i++) begin
      scl = ~scl; sda_m = ~sda_m; tick(1);
    end
    scl = 1'b1; sda_m = 1'b1; tick(2);
    chk("reset_sda_oe", {7'd0, sda_oe}, 8'h00);
    chk("reset_busy", {7'd0, busy}, 8'h00);
    chk("reset_readdata", av.readdata, 8'h00);
    reset_n = 1'b1;
    tick(4);

    // I2C write of two bytes from pointer 1
    i2c_start;
    wr_byte(8'h78, 1'b0);
    wr_byte(8'h01, 1'b0);
    chk("busy_in_write", {7'd0, busy}, 8'h01);
    wr_byte(8'hA5, 1'b0);
    wr_byte(8'h5A, 1'b0);
    i2c_stop;
    tick(2);
    chk("busy_after_stop", {7'd0, busy}, 8'h00);
    chk("strobes_write", 8'(strobe_cnt), 8'd2);
    av_read(2'd1, 8'hA5);
    av_read(2'd2, 8'h5A);

    // Read with pointer wrap through a repeated START
    av_write(2'd3, 8'h81);
    av_write(2'd0, 8'h7E);
    i2c_start;
    wr_byte(8'h78, 1'b0);
    wr_byte(8'h03, 1'b0);
    i2c_start;
    wr_byte(8'h79, 1'b0);
    rd_byte(8'h81, 1'b0);
    rd_byte(8'h7E, 1'b1);
    chk("oe_after_nack", {7'd0, sda_oe}, 8'h00);
    i2c_stop;
    chk("strobes_read", 8'(strobe_cnt), 8'd2);

    // Foreign address: no ACK, following byte ignored
    i2c_start;
    wr_byte(8'h7A, 1'b1);
    chk("busy_mismatch", {7'd0, busy}, 8'h00);
    wr_byte(8'h55, 1'b1);
    i2c_stop;
    chk("strobes_mismatch", 8'(strobe_cnt), 8'd2);
    av_read(2'd0, 8'h7E);
    av_read(2'd1, 8'hA5);
    av_read(2'd2, 8'h5A);
    av_read(2'd3, 8'h81);

    // STOP in the middle of a data byte
    i2c_start;
    wr_byte(8'h78, 1'b0);
    wr_byte(8'h00, 1'b0);
    i2c_bit(1'b1); i2c_bit(1'b1); i2c_bit(1'b0); i2c_bit(1'b0);
    i2c_stop;
    tick(2);
    chk("abort_sda_oe", {7'd0, sda_oe}, 8'h00);
    chk("abort_busy", {7'd0, busy}, 8'h00);
    chk("strobes_abort", 8'(strobe_cnt), 8'd2);
    av_read(2'd0, 8'h7E);

    // CPU write lands in the same clk as the I2C commit to reg1
    i2c_start;
    wr_byte(8'h78, 1'b0);
    wr_byte(8'h01, 1'b0);
    cd = 8'h22;
    frame_q.push_back({8'h22, 1'b0});
    for (int i = 7; i >= 1; i--) i2c_bit(cd[i]);
    sda_m = cd[0]; tick(Q);
    scl = 1'b1; tick(Q);
    scl = 1'b0;
    tick(2);
    av.address = 2'd1; av.writedata = 8'h11; av.chipselect = 1'b1; av.write_n = 1'b0;
    tick(1);
    av.chipselect = 1'b0; av.write_n = 1'b1;
    tick(1);
    i2c_bit(1'b1);
    i2c_stop;
    chk("strobes_collision", 8'(strobe_cnt), 8'd3);
    av_read(2'd1, 8'h11);

    // Reset pulse while the address ACK is being driven
    i2c_start;
    cd = 8'h78;
    for (int i = 7; i >= 0; i--) i2c_bit(cd[i]);
    chk("ack_driven", {7'd0, sda_oe}, 8'h01);
    chk("busy_at_ack", {7'd0, busy}, 8'h01);
    reset_n = 1'b0;
    #1;
    chk("async_release", {7'd0, sda_oe}, 8'h00);
    chk("busy_in_reset", {7'd0, busy}, 8'h00);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    sda_m = 1'b1; tick(Q);
    scl = 1'b1; tick(Q);
    av_read(2'd1, 8'h00);

    checks = checks + 1;
    if (frame_q.size() != 0 || rd_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL pending_expectations frames=%0d reads=%0d exp=0", frame_q.size(), rd_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
